// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns PC and instruction register and
// fetches one word per req/ack handshake, with misalignment and timeout faults.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_old,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic        instr_valid,
  output logic        fetch_done,
  output logic        busy,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FAULT} state_t;

  localparam logic [9:0]  CNT_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  state_t     state;
  state_t     state_next;
  logic [9:0] cnt;
  logic       aligned;
  logic       timeout_hit;

  assign aligned     = (pc[1:0] == 2'b00);
  assign timeout_hit = (cnt == CNT_LAST);
  assign pc_plus4    = pc + 32'd4;
  assign op          = instr[6:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // An ack in the timeout cycle takes priority over the fault.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (fetch_en) state_next = aligned ? S_WAIT : S_FAULT;
      S_WAIT: begin
        if (imem_ack)         state_next = S_IDLE;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == S_WAIT);
    fetch_fault = (state == S_FAULT);
  end

  // pc_write is independent of the FSM; the fetch samples the pre-write pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pc_old      <= '0;
      instr       <= NOP;
      instr_valid <= 1'b0;
      fetch_done  <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      fault_cause <= 2'b00;
      cnt         <= '0;
    end else begin
      fetch_done <= 1'b0;
      if (pc_write) pc <= pc_next;
      unique case (state)
        S_IDLE: begin
          if (fetch_en) begin
            if (aligned) begin
              imem_addr   <= pc;
              imem_req    <= 1'b1;
              instr_valid <= 1'b0;
              cnt         <= '0;
            end else begin
              fault_cause <= 2'b01;
            end
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            pc_old      <= imem_addr;
            instr_valid <= 1'b1;
            fetch_done  <= 1'b1;
            imem_req    <= 1'b0;
          end else if (timeout_hit) begin
            imem_req    <= 1'b0;
            fault_cause <= 2'b10;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: one default instance and one with a
// short timeout and non-zero reset PC, both sharing the same input stimulus.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        pc_write;
  logic [31:0] pc_next;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  logic [31:0] imem_addr, pc, pc_old, pc_plus4, instr;
  logic [6:0]  op;
  logic        imem_req, instr_valid, fetch_done, busy, fetch_fault;
  logic [1:0]  fault_cause;

  logic [31:0] t_imem_addr, t_pc, t_pc_old, t_pc_plus4, t_instr;
  logic [6:0]  t_op;
  logic        t_imem_req, t_instr_valid, t_fetch_done, t_busy, t_fetch_fault;
  logic [1:0]  t_fault_cause;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_write(pc_write), .pc_next(pc_next),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .pc(pc), .pc_old(pc_old), .pc_plus4(pc_plus4), .instr(instr), .op(op),
    .instr_valid(instr_valid), .fetch_done(fetch_done), .busy(busy),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_write(pc_write), .pc_next(pc_next),
    .imem_addr(t_imem_addr), .imem_req(t_imem_req), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .pc(t_pc), .pc_old(t_pc_old), .pc_plus4(t_pc_plus4), .instr(t_instr), .op(t_op),
    .instr_valid(t_instr_valid), .fetch_done(t_fetch_done), .busy(t_busy),
    .fetch_fault(t_fetch_fault), .fault_cause(t_fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; fetch_en = 1'b0; pc_write = 1'b0; pc_next = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4); end
    n_checks++; if (pc_old !== 32'h0) begin n_fail++; $display("FAIL reset_pc_old: got %h want %h", pc_old, 32'h0); end
    n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr, 32'h13); end
    n_checks++; if (op !== 7'b0010011) begin n_fail++; $display("FAIL reset_op: got %b want %b", op, 7'b0010011); end
    n_checks++; if ({instr_valid, fetch_done, imem_req, busy, fetch_fault} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want %b", {instr_valid, fetch_done, imem_req, busy, fetch_fault}, 5'b0); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
    n_checks++; if (fault_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause: got %b want %b", fault_cause, 2'b00); end
    n_checks++; if (t_pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc_param: got %h want %h", t_pc, 32'h100); end
    n_checks++; if (t_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL reset_pc_plus4_param: got %h want %h", t_pc_plus4, 32'h104); end
  endtask

  task automatic test_basic_fetch();
    apply_reset();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    n_checks++; if ({imem_req, busy} !== 2'b11) begin n_fail++; $display("FAIL basic_req_busy: got %b want %b", {imem_req, busy}, 2'b11); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr: got %h want %h", imem_addr, 32'h0); end
    n_checks++; if (fetch_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early: got %b want %b", fetch_done, 1'b0); end
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_instr: got %h want %h", instr, 32'h0050_0093); end
    n_checks++; if (op !== 7'b0010011) begin n_fail++; $display("FAIL basic_op: got %b want %b", op, 7'b0010011); end
    n_checks++; if (pc_old !== 32'h0) begin n_fail++; $display("FAIL basic_pc_old: got %h want %h", pc_old, 32'h0); end
    n_checks++; if ({fetch_done, instr_valid, imem_req, busy} !== 4'b1100) begin n_fail++; $display("FAIL basic_flags: got %b want %b", {fetch_done, instr_valid, imem_req, busy}, 4'b1100); end
    step();
    n_checks++; if ({fetch_done, instr_valid} !== 2'b01) begin n_fail++; $display("FAIL basic_done_pulse: got %b want %b", {fetch_done, instr_valid}, 2'b01); end
    n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_instr_hold: got %h want %h", instr, 32'h0050_0093); end
  endtask

  task automatic test_wait_pc_write();
    apply_reset();
    fetch_en = 1'b1; pc_write = 1'b1; pc_next = 32'h4;
    step();
    fetch_en = 1'b0; pc_write = 1'b0;
    n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL wait_pc_after_write: got %h want %h", pc, 32'h4); end
    for (int c = 1; c <= 5; c++) begin
      n_checks++; if ({busy, imem_req, instr_valid} !== 3'b110) begin n_fail++; $display("FAIL wait_busy_c%0d: got %b want %b", c, {busy, imem_req, instr_valid}, 3'b110); end
      n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wait_addr_c%0d: got %h want %h", c, imem_addr, 32'h0); end
      pc_write = (c == 2); pc_next = 32'h8;
      imem_ack = (c == 5); imem_rdata = 32'h0000_006F;
      step();
    end
    pc_write = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL wait_pc_write_in_wait: got %h want %h", pc, 32'h8); end
    n_checks++; if (instr !== 32'h0000_006F) begin n_fail++; $display("FAIL wait_instr: got %h want %h", instr, 32'h6F); end
    n_checks++; if (pc_old !== 32'h0) begin n_fail++; $display("FAIL wait_pc_old: got %h want %h", pc_old, 32'h0); end
    n_checks++; if ({busy, fetch_done, instr_valid, imem_req} !== 4'b0110) begin n_fail++; $display("FAIL wait_done_flags: got %b want %b", {busy, fetch_done, instr_valid, imem_req}, 4'b0110); end
  endtask

  task automatic test_misaligned();
    apply_reset();
    pc_write = 1'b1; pc_next = 32'h2;
    step();
    pc_write = 1'b0;
    n_checks++; if (pc_plus4 !== 32'h6) begin n_fail++; $display("FAIL mis_pc_plus4: got %h want %h", pc_plus4, 32'h6); end
    fetch_en = 1'b1;
    step();
    n_checks++; if ({fetch_fault, imem_req, busy} !== 3'b100) begin n_fail++; $display("FAIL mis_fault: got %b want %b", {fetch_fault, imem_req, busy}, 3'b100); end
    n_checks++; if (fault_cause !== 2'b01) begin n_fail++; $display("FAIL mis_cause: got %b want %b", fault_cause, 2'b01); end
    pc_write = 1'b1; pc_next = 32'hC; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    pc_write = 1'b0;
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL mis_pc_write_in_fault: got %h want %h", pc, 32'hC); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if ({fetch_fault, imem_req, fetch_done} !== 3'b100) begin n_fail++; $display("FAIL mis_stuck_%0d: got %b want %b", c, {fetch_fault, imem_req, fetch_done}, 3'b100); end
    end
    n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL mis_instr_unchanged: got %h want %h", instr, 32'h13); end
    apply_reset();
    n_checks++; if ({fetch_fault, fault_cause} !== 3'b000) begin n_fail++; $display("FAIL mis_reset_clears: got %b want %b", {fetch_fault, fault_cause}, 3'b000); end
  endtask

  task automatic test_timeout();
    apply_reset();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if ({t_imem_req, t_busy, t_fetch_fault} !== 3'b110) begin n_fail++; $display("FAIL to_wait_c%0d: got %b want %b", c, {t_imem_req, t_busy, t_fetch_fault}, 3'b110); end
      step();
    end
    n_checks++; if ({t_imem_req, t_busy, t_fetch_fault} !== 3'b001) begin n_fail++; $display("FAIL to_fault: got %b want %b", {t_imem_req, t_busy, t_fetch_fault}, 3'b001); end
    n_checks++; if (t_fault_cause !== 2'b10) begin n_fail++; $display("FAIL to_cause: got %b want %b", t_fault_cause, 2'b10); end
    apply_reset();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      imem_ack = (c == 4); imem_rdata = 32'h0000_0033;
      step();
    end
    imem_ack = 1'b0;
    n_checks++; if ({t_fetch_fault, t_fault_cause} !== 3'b000) begin n_fail++; $display("FAIL to_ack_wins_fault: got %b want %b", {t_fetch_fault, t_fault_cause}, 3'b000); end
    n_checks++; if ({t_fetch_done, t_instr_valid, t_imem_req} !== 3'b110) begin n_fail++; $display("FAIL to_ack_wins_flags: got %b want %b", {t_fetch_done, t_instr_valid, t_imem_req}, 3'b110); end
    n_checks++; if (t_instr !== 32'h0000_0033) begin n_fail++; $display("FAIL to_ack_wins_instr: got %h want %h", t_instr, 32'h33); end
    n_checks++; if (t_pc_old !== 32'h100) begin n_fail++; $display("FAIL to_ack_wins_pc_old: got %h want %h", t_pc_old, 32'h100); end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    fetch_en = 1'b1; pc_write = 1'b1; pc_next = 32'h8;
    step();
    fetch_en = 1'b0; pc_write = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hAAAA_AAA3;
    step();
    imem_ack = 1'b0;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL mid_pre_wait: got %b/%h want 1/%h", imem_req, imem_addr, 32'h8); end
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    reset = 1'b0; imem_ack = 1'b0;
    n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL mid_instr: got %h want %h", instr, 32'h13); end
    n_checks++; if ({instr_valid, imem_req, fetch_done, busy} !== 4'b0000) begin n_fail++; $display("FAIL mid_flags: got %b want %b", {instr_valid, imem_req, fetch_done, busy}, 4'b0000); end
    n_checks++; if ({pc, pc_old, imem_addr} !== 96'h0) begin n_fail++; $display("FAIL mid_regs: got %h/%h/%h want 0/0/0", pc, pc_old, imem_addr); end
    step();
    n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL mid_instr_after: got %h want %h", instr, 32'h13); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] word;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      fetch_en = 1'b1; pc_write = 1'b1; pc_next = 32'(4 * (i + 1)); imem_ack = 1'b0;
      step();
      fetch_en = 1'b0; pc_write = 1'b0;
      n_checks++; if ({imem_req, instr_valid, fetch_done} !== 3'b100) begin n_fail++; $display("FAIL b2b_wait_%0d: got %b want %b", i, {imem_req, instr_valid, fetch_done}, 3'b100); end
      n_checks++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL b2b_addr_%0d: got %h want %h", i, imem_addr, 32'(4 * i)); end
      word = 32'h0000_0093 | (32'(i + 1) << 20);
      imem_ack = 1'b1; imem_rdata = word;
      step();
      n_checks++; if ({fetch_done, instr_valid} !== 2'b11) begin n_fail++; $display("FAIL b2b_done_%0d: got %b want %b", i, {fetch_done, instr_valid}, 2'b11); end
      n_checks++; if (pc_old !== 32'(4 * i)) begin n_fail++; $display("FAIL b2b_pc_old_%0d: got %h want %h", i, pc_old, 32'(4 * i)); end
      n_checks++; if (instr !== word) begin n_fail++; $display("FAIL b2b_instr_%0d: got %h want %h", i, instr, word); end
    end
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ack = 1'b0;
    n_checks++; if (instr !== 32'h0030_0093) begin n_fail++; $display("FAIL b2b_stray_ack_instr: got %h want %h", instr, 32'h0030_0093); end
    n_checks++; if ({fetch_done, instr_valid, imem_req} !== 3'b010) begin n_fail++; $display("FAIL b2b_stray_ack_flags: got %b want %b", {fetch_done, instr_valid, imem_req}, 3'b010); end
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL b2b_pc: got %h want %h", pc, 32'hC); end
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; pc_write = 1'b0; pc_next = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    step();
    test_reset();
    test_basic_fetch();
    test_wait_pc_write();
    test_misaligned();
    test_timeout();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
